// File: rtl/escalonador_processos.sv
// escalonador_processos: round-robin process scheduler feeding the PC
// context-switch path.
//   clk, reset    : clock (rising edge), asynchronous active-high reset
//   ready         : per-slot "loaded and runnable" level
//   fim_proc      : pulse, current process executed its last instruction
//   stall         : freezes the quantum counter
//   quantum       : slice length in non-stalled cycles (0 = no preemption)
//   troca_ack     : PC has applied hd_set
//   troca_req     : context-switch request (hd_set valid while high)
//   hd_set        : process to switch to
//   proc_atual    : process currently owning the PC
//   ocioso        : no eligible process
//   trocas        : completed-switch counter, wraps
module escalonador_processos #(
   parameter int unsigned NUM_PROC = 5,
   parameter int unsigned PROC_W   = 10,
   parameter int unsigned QUANT_W  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_PROC-1:0] ready,
   input  logic                fim_proc,
   input  logic                stall,
   input  logic [QUANT_W-1:0]  quantum,
   input  logic                troca_ack,
   output logic                troca_req,
   output logic [PROC_W-1:0]   hd_set,
   output logic [PROC_W-1:0]   proc_atual,
   output logic                ocioso,
   output logic [15:0]         trocas
);

   localparam int unsigned IDX_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
   localparam int          NP    = int'(NUM_PROC);

   typedef enum logic [1:0] {
      S_OCIOSO,
      S_SELECIONA,
      S_TROCA,
      S_EXECUTA
   } state_t;

   state_t              r_state;
   logic [NUM_PROC-1:0] r_done;
   logic [IDX_W-1:0]    r_ult;
   logic [QUANT_W-1:0]  r_cnt;
   logic                r_troca_req;
   logic [PROC_W-1:0]   r_hd_set;
   logic [PROC_W-1:0]   r_proc_atual;
   logic                r_ocioso;
   logic [15:0]         r_trocas;

   logic [NUM_PROC-1:0] w_eleg;
   logic [NUM_PROC-1:0] w_cur_oh;
   logic [NUM_PROC-1:0] w_others;
   logic [NUM_PROC-1:0] w_done_set;
   logic [IDX_W-1:0]    w_winner;
   int                  w_best;
   logic                w_leave;
   logic                w_tick;
   logic                w_expire;

   assign troca_req  = r_troca_req;
   assign hd_set     = r_hd_set;
   assign proc_atual = r_proc_atual;
   assign ocioso     = r_ocioso;
   assign trocas     = r_trocas;

   assign w_eleg = ready & ~r_done;

   // One-hot decode of the running process
   always_comb begin
      w_cur_oh = '0;
      for (int i = 0; i < NP; i++) begin
         w_cur_oh[i] = (r_proc_atual == PROC_W'(i));
      end
   end

   assign w_others = w_eleg & ~w_cur_oh;

   // Round-robin pick: distance 0 is ult+1, ult itself is distance NP-1
   always_comb begin
      w_winner = '0;
      w_best   = NP;
      for (int i = 0; i < NP; i++) begin
         if (w_eleg[i] && (((i + NP - 1 - int'(r_ult)) % NP) < w_best)) begin
            w_best   = (i + NP - 1 - int'(r_ult)) % NP;
            w_winner = IDX_W'(i);
         end
      end
   end

   // Current process leaves the CPU: finished or unloaded
   assign w_leave    = fim_proc | ~(|(ready & w_cur_oh));
   assign w_done_set = ((r_state == S_EXECUTA) && w_leave) ? w_cur_oh : '0;

   // Counter never underflows; quantum==0 disables preemption
   assign w_tick   = ~stall & (quantum != '0) & (r_cnt != '0);
   assign w_expire = w_tick & (r_cnt == QUANT_W'(1));

   // Scheduler FSM with registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_OCIOSO;
         r_done       <= '0;
         r_ult        <= IDX_W'(NUM_PROC - 1);
         r_cnt        <= '0;
         r_troca_req  <= 1'b0;
         r_hd_set     <= '0;
         r_proc_atual <= '0;
         r_ocioso     <= 1'b1;
         r_trocas     <= '0;
      end else begin
         // Unloading a slot re-arms it for the next load
         r_done <= (r_done | w_done_set) & ready;

         case (r_state)
            S_OCIOSO: begin
               if (|w_eleg) begin
                  r_state  <= S_SELECIONA;
                  r_ocioso <= 1'b0;
               end
            end

            S_SELECIONA: begin
               if (|w_eleg) begin
                  r_hd_set <= PROC_W'(w_winner);
                  r_ult    <= w_winner;
                  r_state  <= S_TROCA;
               end else begin
                  r_state  <= S_OCIOSO;
                  r_ocioso <= 1'b1;
               end
            end

            // Request rises one cycle after entry; ack only counts while it is high
            S_TROCA: begin
               if (!r_troca_req) begin
                  r_troca_req <= 1'b1;
               end else if (troca_ack) begin
                  r_troca_req  <= 1'b0;
                  r_proc_atual <= r_hd_set;
                  r_cnt        <= quantum;
                  r_trocas     <= r_trocas + 16'd1;
                  r_state      <= S_EXECUTA;
               end
            end

            S_EXECUTA: begin
               if (w_leave) begin
                  if (|w_others) begin
                     r_state <= S_SELECIONA;
                  end else begin
                     r_state  <= S_OCIOSO;
                     r_ocioso <= 1'b1;
                  end
               end else if (w_expire) begin
                  if (|w_others) begin
                     r_cnt   <= '0;
                     r_state <= S_SELECIONA;
                  end else begin
                     r_cnt <= quantum;
                  end
               end else if (w_tick) begin
                  r_cnt <= r_cnt - QUANT_W'(1);
               end
            end

            default: begin
               r_state <= S_OCIOSO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_escalonador_processos.sv
// tb_escalonador_processos: directed bench for escalonador_processos.
// Expected hd_set values are queued when stimulus makes a switch due and
// popped when the DUT raises troca_req.
module tb_escalonador_processos;

   localparam int unsigned NUM_PROC = 5;
   localparam int unsigned PROC_W   = 10;
   localparam int unsigned QUANT_W  = 8;

   logic                clk;
   logic                reset;
   logic [NUM_PROC-1:0] ready;
   logic                fim_proc;
   logic                stall;
   logic [QUANT_W-1:0]  quantum;
   logic                troca_ack;
   logic                troca_req;
   logic [PROC_W-1:0]   hd_set;
   logic [PROC_W-1:0]   proc_atual;
   logic                ocioso;
   logic [15:0]         trocas;

   int n_cmp = 0;
   int n_mis = 0;
   logic [PROC_W-1:0] exp_q[$];

   escalonador_processos #(
      .NUM_PROC (NUM_PROC),
      .PROC_W   (PROC_W),
      .QUANT_W  (QUANT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ready      (ready),
      .fim_proc   (fim_proc),
      .stall      (stall),
      .quantum    (quantum),
      .troca_ack  (troca_ack),
      .troca_req  (troca_req),
      .hd_set     (hd_set),
      .proc_atual (proc_atual),
      .ocioso     (ocioso),
      .trocas     (trocas)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for troca_req, then check hd_set against the scoreboard
   task automatic wait_req(input string tag, input int budget, output int cycles);
      logic [PROC_W-1:0] e;
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!troca_req && cycles < budget);
      chk({tag, "_req"}, 32'(troca_req), 32'd1);
      if (troca_req) begin
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_hd_set"}, 32'(hd_set), 32'(e));
         end else begin
            n_mis++;
            $error("FAIL %s_scoreboard: observed request for %0d expected none", tag, hd_set);
         end
      end
   endtask

   initial begin
      int cyc;
      reset     = 1'b1;
      ready     = '0;
      fim_proc  = 1'b0;
      stall     = 1'b0;
      quantum   = 8'd3;
      troca_ack = 1'b1;
      tick(3);
      chk("rst_hd_set", 32'(hd_set), 32'd0);
      chk("rst_proc_atual", 32'(proc_atual), 32'd0);
      reset = 1'b0;

      // Idle: nothing loaded for 20 cycles
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("idle_ocioso", 32'(ocioso), 32'd1);
         chk("idle_req", 32'(troca_req), 32'd0);
         chk("idle_trocas", 32'(trocas), 32'd0);
      end

      // All five loaded, quantum 3, ack tied high: 0,1,2,3,4,0 six cycles apart
      ready = 5'b11111;
      for (int p = 0; p < 6; p++) exp_q.push_back(PROC_W'(p % 5));
      wait_req("rr0", 40, cyc);
      chk("rr0_latency", 32'(cyc), 32'd3);
      for (int p = 1; p < 6; p++) begin
         wait_req("rr", 40, cyc);
         chk("rr_period", 32'(cyc), 32'd6);
      end
      tick(1);
      chk("rr_trocas", 32'(trocas), 32'd6);
      chk("rr_proc_atual", 32'(proc_atual), 32'd0);

      // Slots 0 and 2: finish proc 0, expect 2
      ready    = 5'b00101;
      fim_proc = 1'b1;
      exp_q.push_back(PROC_W'(2));
      tick(1);
      fim_proc = 1'b0;
      wait_req("fim0", 40, cyc);
      chk("fim0_latency", 32'(cyc), 32'd2);
      // Only proc 2 eligible: expiries reload silently
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("solo_req", 32'(troca_req), 32'd0);
      end
      chk("solo_trocas", 32'(trocas), 32'd7);
      chk("solo_proc_atual", 32'(proc_atual), 32'd2);
      chk("solo_ocioso", 32'(ocioso), 32'd0);
      fim_proc = 1'b1;
      tick(1);
      fim_proc = 1'b0;
      chk("fim2_ocioso", 32'(ocioso), 32'd1);
      chk("fim2_req", 32'(troca_req), 32'd0);

      // Unload to re-arm, then slots 0/1 with quantum 4 and a 5-cycle stall
      ready = '0;
      tick(1);
      ready   = 5'b00011;
      quantum = 8'd4;
      exp_q.push_back(PROC_W'(0));
      exp_q.push_back(PROC_W'(1));
      wait_req("st0", 40, cyc);
      chk("st0_latency", 32'(cyc), 32'd3);
      tick(2);
      stall = 1'b1;
      tick(5);
      stall = 1'b0;
      wait_req("st1", 40, cyc);
      chk("st1_tail", 32'(cyc), 32'd5);

      // Delayed ack: request held 7 cycles
      troca_ack = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk("hold_req", 32'(troca_req), 32'd1);
         chk("hold_hd_set", 32'(hd_set), 32'd1);
         chk("hold_proc_atual", 32'(proc_atual), 32'd0);
         if (i < 6) tick(1);
      end
      troca_ack = 1'b1;
      tick(1);
      chk("ack_req", 32'(troca_req), 32'd0);
      chk("ack_proc_atual", 32'(proc_atual), 32'd1);
      chk("ack_trocas", 32'(trocas), 32'd9);

      // fim_proc on the expiry cycle of proc 1
      tick(3);
      fim_proc = 1'b1;
      exp_q.push_back(PROC_W'(0));
      tick(1);
      fim_proc = 1'b0;
      wait_req("fx", 40, cyc);
      chk("fx_latency", 32'(cyc), 32'd2);
      for (int i = 0; i < 12; i++) begin
         tick(1);
         chk("fx_no_resel", 32'(troca_req), 32'd0);
      end
      chk("fx_proc_atual", 32'(proc_atual), 32'd0);
      chk("fx_trocas", 32'(trocas), 32'd10);

      // Reload slot 1: eligible again
      ready = 5'b00001;
      tick(1);
      ready = 5'b00011;
      exp_q.push_back(PROC_W'(1));
      wait_req("rearm", 40, cyc);
      chk("rearm_trocas", 32'(trocas), 32'd10);

      // Reset mid-handshake drops the request without a clock edge
      #1;
      reset = 1'b1;
      #1;
      chk("arst_req", 32'(troca_req), 32'd0);
      chk("arst_ocioso", 32'(ocioso), 32'd1);
      chk("arst_trocas", 32'(trocas), 32'd0);
      chk("arst_hd_set", 32'(hd_set), 32'd0);
      tick(2);
      reset = 1'b0;
      tick(2);
      chk("post_rst_req", 32'(troca_req), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/escalonador_processos.md
# escalonador_processos

Round-robin process scheduler that sits in front of the program counter's context-switch path. It tracks up to five loaded processes and grants each a programmable time quantum. It also retires processes that reach their last instruction. It requests context switches by presenting the next process number on `hd_set` under a request/acknowledge handshake; the datapath control issues the process-switch command to the PC on acknowledge.

## Interface
- `NUM_PROC`, 5: number of process slots; must match the PC's per-process register count.
- `PROC_W`, 10: width of process identifiers.
- `QUANT_W`, 8: width of the quantum counter.

- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `ready`  in  NUM_PROC: level; bit i = process i loaded and runnable.
- `fim_proc`  in  1: one-cycle pulse; the current process executed its last instruction.
- `stall`  in  1: level; freezes the quantum counter (multi-cycle instruction, overflow hold).
- `quantum`  in  QUANT_W: slice length in non-stalled cycles; 0 = no preemption.
- `troca_ack`  in  1: PC has applied `hd_set`.
- `troca_req`  out  1: context-switch request.
- `hd_set`  out  PROC_W: process to switch to; valid while `troca_req`=1.
- `proc_atual`  out  PROC_W: process currently owning the PC.
- `ocioso`  out  1: no eligible process.
- `trocas`  out  16: count of completed switches; wraps at 0xFFFF→0.

## Operation
- Eligibility:
  - `eleg[i] = ready[i] & ~done[i]`.
  - `done[i]` is set when `fim_proc` occurs while process i is current.
  - `done[i]` clears whenever `ready[i]`=0, so a reload re-arms the slot.
- Selection is round-robin.
  - Search order is `ult+1 … ult+NUM_PROC`, modulo NUM_PROC with wrap.
  - `ult` is the last selected slot.
  - The first eligible slot in that order wins.
  - The search includes `ult` itself, checked last.
- States:
  - OCIOSO: `ocioso`=1. Any `eleg` bit set → SELECIONA.
  - SELECIONA: one cycle. Latch the winner into `hd_set` and `ult`. → TROCA. If `eleg` has since cleared → OCIOSO.
  - TROCA: hold `troca_req`=1 and keep `hd_set` stable until `troca_ack`=1 is sampled. On that edge:
    - `proc_atual` ← `hd_set`
    - counter ← `quantum`
    - `trocas` ← `trocas`+1
    - `troca_req` ← 0
    - → EXECUTA.
  - EXECUTA: on each cycle with `stall`=0 and `quantum`≠0, counter ← counter−1.
    - `fim_proc`=1, or `ready[proc_atual]`=0: set `done[proc_atual]`; → SELECIONA if any slot remains eligible, else → OCIOSO.
    - Counter goes 1→0, another slot eligible: → SELECIONA.
    - Counter goes 1→0, only the current slot eligible: reload counter from `quantum` and stay in EXECUTA; no request, `trocas` unchanged.
- Priority within a cycle:
  - reset
  - then `fim_proc`/unload
  - then quantum expiry
  - then decrement.
- `stall`=1 on the expiry cycle: the counter holds at 1 and expiry is deferred.
- `fim_proc`, `stall` and `troca_ack` are ignored outside the states where they are used.
- Quantum width rules:
  - `quantum` is sampled only at counter load.
  - Changes mid-slice take effect at the next load.
  - The counter is QUANT_W bits, unsigned, with no underflow below 0.

## Timing
- Reset values:
  - state OCIOSO
  - `troca_req`=0, `hd_set`=0, `proc_atual`=0
  - `ocioso`=1, `trocas`=0
  - `done`=0, counter=0
  - `ult`=NUM_PROC−1, so process 0 is selected first.
- Reset asserted mid-handshake drops `troca_req` immediately (asynchronous).
- Latency:
  - First `eleg` bit seen in OCIOSO at edge n → `troca_req`=1 after edge n+2.
  - `fim_proc` sampled at edge n → `troca_req`=1 after edge n+2.
- Handshake:
  - Minimum request length is one cycle when `troca_ack` is tied high.
  - `troca_ack` sampled while `troca_req`=0 has no effect.
- Slice length: exactly `quantum` non-stalled EXECUTA cycles. With Q and no stall, consecutive `troca_req` assertions are Q+3 cycles apart: Q in EXECUTA, plus SELECIONA, plus TROCA with immediate ack.
- Outputs are registered; no combinational input→output paths.

## Test plan
- Reset, then `ready`=00000: `ocioso`=1, `troca_req`=0, `trocas`=0; hold for 20 cycles with no change.
- `ready`=11111, `quantum`=3, `troca_ack`=1: `hd_set` sequence 0,1,2,3,4,0; `troca_req` pulses 6 cycles apart; `trocas`=6.
- `ready`=00101, proc 0 running, `fim_proc` pulse: `done[0]` set; next `hd_set`=2.
  - Quantum expiry then reloads with no request.
  - `fim_proc` on proc 2 → `ocioso`=1.
- `quantum`=4, `stall` high for 5 cycles mid-slice: slice ends after 4 non-stalled cycles, i.e. 9 EXECUTA cycles total.
- `troca_ack` delayed 7 cycles: `troca_req` and `hd_set` stable for 7 cycles; `proc_atual` updates only on the ack edge.
- `fim_proc` on the same cycle as quantum expiry: the current process is marked done and never reselected. Then `ready` bit cleared and re-set: the slot becomes eligible again. Reset asserted during TROCA: `troca_req`=0 immediately.
